sipo_deser: RTL and testbench

//  Receive-side counterpart of the 4-stage parallel-in/serial-out shifter: collects a serial

---
 rtl/sipo_piso_pkg.sv | 15 +
 rtl/sipo_deser_if.sv | 25 ++
 rtl/sipo_deser_shift_core.sv | 45 ++++
 rtl/sipo_deser.sv | 67 ++++++
 tb/tb_sipo_deser.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_piso_pkg.sv
// Shared constants for the PISO/SIPO serial link pair.
package sipo_piso_pkg;

  // Bit-order selector values, shared with the transmitter so both ends agree.
  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

  // Width of a bit counter that must hold 0..width-1.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-in / word-out bus of the deserializer.
interface sipo_deser_if #(parameter int WIDTH = 4) ();

  logic             sin;
  logic             sin_en;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overflow;

  // Deserializer side.
  modport slave (
    input  sin, sin_en, clr, dout_ready,
    output dout, dout_valid, busy, overflow
  );

  // Link/consumer side.
  modport master (
    output sin, sin_en, clr, dout_ready,
    input  dout, dout_valid, busy, overflow
  );

endinterface

// File: rtl/sipo_deser_shift_core.sv
// Shift register and bit counter; flags the bit that completes a word.
module sipo_shift_core
  import sipo_piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             sin,
  input  logic             sin_en,
  output logic             word_done,
  output logic [WIDTH-1:0] word_nxt,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  // Next shift value; word_nxt is the full word when this bit completes it.
  always_comb begin
    if (MSB_FIRST) word_nxt = {sh[WIDTH-2:0], sin};
    else           word_nxt = {sin, sh[WIDTH-1:1]};
  end

  // Completion is a one-cycle pulse on the qualified last bit of a word.
  assign word_done = sin_en && (cnt == LAST);
  assign busy      = (cnt != '0);

  // Shift and count only on qualified bits; the count wraps at WIDTH-1 so
  // non power-of-two widths frame correctly.
  always_ff @(posedge clk) begin
    if (srst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (sin_en) begin
      sh  <= word_nxt;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a held, handshaked output word.
module sipo_deser
  import sipo_piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);

  logic             srst;
  logic             word_done;
  logic [WIDTH-1:0] word_nxt;
  logic             core_busy;
  logic [WIDTH-1:0] dout_q;
  logic             vld_q;
  logic             ovf_q;
  logic             busy_q;

  // Soft clear behaves exactly like reset.
  assign srst = rst || bus.clr;

  sipo_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk      (clk),
    .srst     (srst),
    .sin      (bus.sin),
    .sin_en   (bus.sin_en),
    .word_done(word_done),
    .word_nxt (word_nxt),
    .busy     (core_busy)
  );

  // Output register: load on completion when the slot is free or being
  // drained this edge; otherwise drop the word and flag overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (word_done) begin
      if (!vld_q || bus.dout_ready) begin
        dout_q <= word_nxt;
        vld_q  <= 1'b1;
      end else begin
        ovf_q  <= 1'b1;
      end
    end else if (vld_q && bus.dout_ready) begin
      vld_q  <= 1'b0;
    end
  end

  // busy mirrors the core count state; kept as its own flop so the port is a
  // plain register output.
  always_ff @(posedge clk) begin
    if (srst)                      busy_q <= 1'b0;
    else if (bus.sin_en)           busy_q <= !word_done;
    else                           busy_q <= core_busy;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench: two WIDTH=4 instances (MSB/LSB first) share a bit stream,
// a WIDTH=5 instance runs its own stream.
module tb_sipo_deser;
  import sipo_piso_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(4)) if0 ();
  sipo_deser_if #(.WIDTH(4)) if1 ();
  sipo_deser_if #(.WIDTH(5)) if2 ();

  sipo_deser #(.WIDTH(4), .MSB_FIRST(ORDER_MSB_FIRST)) u0 (.clk(clk), .rst(rst), .bus(if0));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(ORDER_LSB_FIRST)) u1 (.clk(clk), .rst(rst), .bus(if1));
  sipo_deser #(.WIDTH(5), .MSB_FIRST(ORDER_MSB_FIRST)) u2 (.clk(clk), .rst(rst), .bus(if2));

  int n_run  = 0;
  int n_fail = 0;
  logic [7:0] q0[$], q1[$], q2[$];
  logic pv[3];
  logic px[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A new word is on dout when valid rises or stays high right after a transfer.
  task automatic mon(input int k, input logic v, input logic r, input logic [7:0] d);
    logic [7:0] e;
    logic       have;
    if (v && (!pv[k] || px[k])) begin
      have = 1'b0;
      e    = '0;
      case (k)
        0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_word dut%0d: got %0h expected none", k, d);
      end else begin
        chk($sformatf("word dut%0d", k), {24'd0, d}, {24'd0, e});
      end
    end
    pv[k] = v;
    px[k] = v && r;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit4(input logic b);
    if0.sin = b; if1.sin = b;
    if0.sin_en = 1'b1; if1.sin_en = 1'b1;
    cyc();
    if0.sin_en = 1'b0; if1.sin_en = 1'b0;
  endtask

  task automatic word4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) bit4(w[i]);
  endtask

  task automatic bit5(input logic b);
    if2.sin = b;
    if2.sin_en = 1'b1;
    cyc();
    if2.sin_en = 1'b0;
  endtask

  task automatic rdy4(input logic r);
    if0.dout_ready = r; if1.dout_ready = r;
  endtask

  task automatic drain4();
    rdy4(1'b1); cyc(); rdy4(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    if0.sin = 0; if0.sin_en = 0; if0.clr = 0; if0.dout_ready = 0;
    if1.sin = 0; if1.sin_en = 0; if1.clr = 0; if1.dout_ready = 0;
    if2.sin = 0; if2.sin_en = 0; if2.clr = 0; if2.dout_ready = 0;
    for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; px[k] = 1'b0; end

    fork
      forever begin
        @(negedge clk);
        mon(0, if0.dout_valid, if0.dout_ready, {4'd0, if0.dout});
        mon(1, if1.dout_valid, if1.dout_ready, {4'd0, if1.dout});
        mon(2, if2.dout_valid, if2.dout_ready, {3'd0, if2.dout});
      end
    join_none

    // Reset state
    cyc(2);
    chk("rst valid", {31'd0, if0.dout_valid}, 0);
    chk("rst dout", {28'd0, if0.dout}, 0);
    chk("rst busy", {31'd0, if0.busy}, 0);
    chk("rst ovf", {31'd0, if0.overflow}, 0);
    chk("rst valid5", {31'd0, if2.dout_valid}, 0);
    rst = 1'b0;
    cyc();

    // 1/2: bits 1,0,1,1 back to back; MSB-first 1011, LSB-first 1101
    q0.push_back(8'hB); q1.push_back(8'hD);
    bit4(1'b1); chk("t1 busy b1", {31'd0, if0.busy}, 1);
    bit4(1'b0); chk("t1 busy b2", {31'd0, if0.busy}, 1);
    bit4(1'b1); chk("t1 busy b3", {31'd0, if1.busy}, 1);
    chk("t1 no early valid", {31'd0, if0.dout_valid}, 0);
    bit4(1'b1);
    chk("t1 valid", {31'd0, if0.dout_valid}, 1);
    chk("t1 dout msb", {28'd0, if0.dout}, 32'hB);
    chk("t1 dout lsb", {28'd0, if1.dout}, 32'hD);
    chk("t1 busy done", {31'd0, if0.busy}, 0);
    cyc(2);
    chk("t1 hold valid", {31'd0, if0.dout_valid}, 1);
    chk("t1 hold dout", {28'd0, if0.dout}, 32'hB);
    drain4();
    chk("t1 drained", {31'd0, if0.dout_valid}, 0);
    chk("t1 dout kept", {28'd0, if0.dout}, 32'hB);

    // 2: same bits with two idle cycles between them
    q0.push_back(8'hB); q1.push_back(8'hD);
    bit4(1'b1); cyc(2);
    bit4(1'b0); cyc(2);
    chk("t2 busy gap", {31'd0, if1.busy}, 1);
    bit4(1'b1); cyc(2);
    bit4(1'b1);
    chk("t2 dout lsb", {28'd0, if1.dout}, 32'hD);
    cyc(2);
    drain4();

    // 3a: ready tied high, A then 5 with no gap
    q0.push_back(8'hA); q0.push_back(8'h5);
    q1.push_back(8'h5); q1.push_back(8'hA);
    rdy4(1'b1);
    word4(4'hA);
    word4(4'h5);
    chk("t3 last valid", {31'd0, if0.dout_valid}, 1);
    chk("t3 last dout", {28'd0, if0.dout}, 32'h5);
    cyc();
    chk("t3 consumed", {31'd0, if0.dout_valid}, 0);
    chk("t3 ovf", {31'd0, if0.overflow}, 0);
    rdy4(1'b0);

    // 3b: completion and transfer on the same edge keep valid high
    q0.push_back(8'hA); q1.push_back(8'h5);
    word4(4'hA);
    q0.push_back(8'h5); q1.push_back(8'hA);
    bit4(1'b0); bit4(1'b1); bit4(1'b0);
    rdy4(1'b1);
    bit4(1'b1);
    chk("t3b valid kept", {31'd0, if0.dout_valid}, 1);
    chk("t3b dout new", {28'd0, if0.dout}, 32'h5);
    chk("t3b ovf", {31'd0, if0.overflow}, 0);
    cyc();
    rdy4(1'b0);
    chk("t3b drained", {31'd0, if0.dout_valid}, 0);

    // 4: overflow drops the second word and is sticky until clr
    q0.push_back(8'h3); q1.push_back(8'hC);
    word4(4'h3);
    word4(4'hC);
    chk("t4 dout kept", {28'd0, if0.dout}, 32'h3);
    chk("t4 dout kept lsb", {28'd0, if1.dout}, 32'hC);
    chk("t4 ovf", {31'd0, if0.overflow}, 1);
    chk("t4 ovf lsb", {31'd0, if1.overflow}, 1);
    drain4();
    chk("t4 valid off", {31'd0, if0.dout_valid}, 0);
    chk("t4 ovf sticky", {31'd0, if0.overflow}, 1);
    if0.clr = 1'b1; if1.clr = 1'b1;
    cyc();
    if0.clr = 1'b0; if1.clr = 1'b0;
    chk("t4 clr ovf", {31'd0, if0.overflow}, 0);
    chk("t4 clr dout", {28'd0, if0.dout}, 0);

    // 5: reset mid-word discards the partial word
    bit4(1'b1); bit4(1'b0);
    chk("t5 busy", {31'd0, if0.busy}, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5 rst valid", {31'd0, if0.dout_valid}, 0);
    chk("t5 rst busy", {31'd0, if0.busy}, 0);
    q0.push_back(8'h9); q1.push_back(8'h9);
    bit4(1'b1); bit4(1'b0); bit4(1'b0);
    chk("t5 no stale", {31'd0, if0.dout_valid}, 0);
    bit4(1'b1);
    chk("t5 dout", {28'd0, if0.dout}, 32'h9);
    chk("t5 dout lsb", {28'd0, if1.dout}, 32'h9);
    drain4();

    // 6: WIDTH=5, bits 1,0,0,1,1 then a second word to prove framing
    q2.push_back(8'h13);
    bit5(1'b1); bit5(1'b0); bit5(1'b0); bit5(1'b1);
    chk("t6 busy b4", {31'd0, if2.busy}, 1);
    chk("t6 no early", {31'd0, if2.dout_valid}, 0);
    bit5(1'b1);
    chk("t6 wrap busy", {31'd0, if2.busy}, 0);
    chk("t6 dout", {27'd0, if2.dout}, 32'h13);
    if2.dout_ready = 1'b1; cyc(); if2.dout_ready = 1'b0;
    q2.push_back(8'h0A);
    bit5(1'b0); bit5(1'b1); bit5(1'b0); bit5(1'b1); bit5(1'b0);
    chk("t6 dout2", {27'd0, if2.dout}, 32'h0A);
    if2.dout_ready = 1'b1; cyc(); if2.dout_ready = 1'b0;

    // Every expected word must have been seen
    cyc(3);
    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    chk("q2 empty", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
